// File: rtl/z80_io_ctrl.sv
// z80_io_ctrl -- Z80 sound-side I/O controller.
//
// Sits on the Z80 bus (SDA / nIORQ / nRD / nWR) and provides:
//   - the 68k->Z80 sound command latch (loaded by SOUND_CMD_WR) and the NMI it raises,
//   - the Z80->68k reply latch (SOUND_REPLY),
//   - YM2610 chip select / register address for ports $04-$07,
//   - NEO-ZMC style ROM bank registers, loaded by IN from $08-$0B with the bank value on SDA[15:8].
//
// Build option: define Z80_BANK_EN to implement the bank registers. Without it, BANK0..3 are
// tied to their reset constants and reads of $08-$0B change no state.
//
// Ports:
//   CLK_24M, nRESET            system clock, async active-low reset
//   SDA, SDD_WR                Z80 address bus and CPU data out
//   nIORQ, nRD, nWR            Z80 strobes (sampled on CLK_24M)
//   SDD_IO, IO_RD              I/O read data and its mux select toward Z80 DI
//   nNMI                       registered NMI to the Z80
//   SOUND_CMD_WR, SOUND_CMD    68k command load strobe and byte
//   SOUND_REPLY                reply latch read by the 68k
//   YM_DOUT, nYMCS, YM_A       YM2610 read data, chip select, register address
//   BANK0..BANK3               ROM bank registers ($F000/$E000/$C000/$8000 windows)

module z80_io_ctrl #(
  parameter logic [7:0] BANK0_RST = 8'h1E,
  parameter logic [7:0] BANK1_RST = 8'h0E,
  parameter logic [7:0] BANK2_RST = 8'h06,
  parameter logic [7:0] BANK3_RST = 8'h02
) (
  input  logic        CLK_24M,
  input  logic        nRESET,
  input  logic [15:0] SDA,
  input  logic [7:0]  SDD_WR,
  input  logic        nIORQ,
  input  logic        nRD,
  input  logic        nWR,
  output logic [7:0]  SDD_IO,
  output logic        IO_RD,
  output logic        nNMI,
  input  logic        SOUND_CMD_WR,
  input  logic [7:0]  SOUND_CMD,
  output logic [7:0]  SOUND_REPLY,
  input  logic [7:0]  YM_DOUT,
  output logic        nYMCS,
  output logic [1:0]  YM_A,
  output logic [7:0]  BANK0,
  output logic [7:0]  BANK1,
  output logic [7:0]  BANK2,
  output logic [7:0]  BANK3
);

  logic       io_rd, io_wr;
  logic [2:0] port;
  logic       rd_edge, wr_edge;

  logic       io_rd_q, io_rd_d;
  logic       io_wr_q, io_wr_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] reply_q, reply_d;
  logic       nmi_en_q, nmi_en_d;
  logic       nmi_pend_q, nmi_pend_d;
  logic       nmi_n_q, nmi_n_d;

  // Interrupt-acknowledge cycles have both nRD and nWR high, so neither strobe is active.
  assign io_rd = ~nIORQ & ~nRD;
  assign io_wr = ~nIORQ & ~nWR;
  assign port  = SDA[4:2];

  // Act once per bus cycle, however long WAIT stretches it.
  assign rd_edge = io_rd & ~io_rd_q;
  assign wr_edge = io_wr & ~io_wr_q;

  assign IO_RD       = io_rd;
  assign nYMCS       = ~((io_rd | io_wr) & (port == 3'd1));
  assign YM_A        = SDA[1:0];
  assign nNMI        = nmi_n_q;
  assign SOUND_REPLY = reply_q;

  always_comb begin
    SDD_IO = 8'hFF;
    case (port)
      3'd0:    SDD_IO = cmd_q;
      3'd1:    SDD_IO = YM_DOUT;
      default: SDD_IO = 8'hFF;
    endcase
  end

  always_comb begin
    io_rd_d    = io_rd;
    io_wr_d    = io_wr;
    cmd_d      = cmd_q;
    reply_d    = reply_q;
    nmi_en_d   = nmi_en_q;
    nmi_pend_d = nmi_pend_q;

    if ((rd_edge || wr_edge) && port == 3'd0)
      nmi_pend_d = 1'b0;
    if (wr_edge && port == 3'd2)
      nmi_en_d = 1'b1;
    if (wr_edge && port == 3'd6)
      nmi_en_d = 1'b0;
    if (wr_edge && port == 3'd3)
      reply_d = SDD_WR;

    // A new command overrides an acknowledge landing on the same clock.
    if (SOUND_CMD_WR) begin
      cmd_d      = SOUND_CMD;
      nmi_pend_d = 1'b1;
    end

    nmi_n_d = ~(nmi_en_q & nmi_pend_q);
  end

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      io_rd_q    <= 1'b0;
      io_wr_q    <= 1'b0;
      cmd_q      <= 8'h00;
      reply_q    <= 8'h00;
      nmi_en_q   <= 1'b0;
      nmi_pend_q <= 1'b0;
      nmi_n_q    <= 1'b1;
    end else begin
      io_rd_q    <= io_rd_d;
      io_wr_q    <= io_wr_d;
      cmd_q      <= cmd_d;
      reply_q    <= reply_d;
      nmi_en_q   <= nmi_en_d;
      nmi_pend_q <= nmi_pend_d;
      nmi_n_q    <= nmi_n_d;
    end
  end

`ifdef Z80_BANK_EN
  logic [7:0] bank_q [4];
  logic [7:0] bank_d [4];

  always_comb begin
    bank_d = bank_q;
    if (rd_edge && port == 3'd2)
      bank_d[SDA[1:0]] = SDA[15:8];
  end

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      bank_q[0] <= BANK0_RST;
      bank_q[1] <= BANK1_RST;
      bank_q[2] <= BANK2_RST;
      bank_q[3] <= BANK3_RST;
    end else begin
      bank_q <= bank_d;
    end
  end

  assign BANK0 = bank_q[0];
  assign BANK1 = bank_q[1];
  assign BANK2 = bank_q[2];
  assign BANK3 = bank_q[3];
`else
  assign BANK0 = BANK0_RST;
  assign BANK1 = BANK1_RST;
  assign BANK2 = BANK2_RST;
  assign BANK3 = BANK3_RST;
`endif

  // Address bits outside the port decode (and the bank value when banking is off).
  logic unused_sda;
  assign unused_sda = ^SDA[15:5];

endmodule

// File: tb/tb_z80_io_ctrl.sv
module tb_z80_io_ctrl;

  logic        CLK_24M = 1'b0;
  logic        nRESET  = 1'b0;
  logic [15:0] SDA     = 16'h0000;
  logic [7:0]  SDD_WR  = 8'h00;
  logic        nIORQ   = 1'b1;
  logic        nRD     = 1'b1;
  logic        nWR     = 1'b1;
  logic [7:0]  SDD_IO;
  logic        IO_RD;
  logic        nNMI;
  logic        SOUND_CMD_WR = 1'b0;
  logic [7:0]  SOUND_CMD    = 8'h00;
  logic [7:0]  SOUND_REPLY;
  logic [7:0]  YM_DOUT      = 8'h00;
  logic        nYMCS;
  logic [1:0]  YM_A;
  logic [7:0]  BANK0, BANK1, BANK2, BANK3;

  z80_io_ctrl dut (
    .CLK_24M(CLK_24M), .nRESET(nRESET), .SDA(SDA), .SDD_WR(SDD_WR),
    .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .SDD_IO(SDD_IO), .IO_RD(IO_RD),
    .nNMI(nNMI), .SOUND_CMD_WR(SOUND_CMD_WR), .SOUND_CMD(SOUND_CMD),
    .SOUND_REPLY(SOUND_REPLY), .YM_DOUT(YM_DOUT), .nYMCS(nYMCS), .YM_A(YM_A),
    .BANK0(BANK0), .BANK1(BANK1), .BANK2(BANK2), .BANK3(BANK3)
  );

  always #5 CLK_24M = ~CLK_24M;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

`ifdef Z80_BANK_EN
  localparam bit BANKING = 1'b1;
`else
  localparam bit BANKING = 1'b0;
`endif

  // Reference model: state of the sound controller as seen by software.
  logic [7:0] m_cmd = 8'h00, m_reply = 8'h00;
  bit         m_en = 0, m_pend = 0, m_nmi_line = 0;
  logic [7:0] m_bank [4] = '{8'h1E, 8'h0E, 8'h06, 8'h02};
  bit         m_in_rd = 0, m_in_wr = 0;   // a bus cycle already acted upon

  always @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      m_cmd = 8'h00; m_reply = 8'h00; m_en = 0; m_pend = 0; m_nmi_line = 0;
      m_bank = '{8'h1E, 8'h0E, 8'h06, 8'h02};
      m_in_rd = 0; m_in_wr = 0;
    end else begin
      bit rd, wr;
      int p;
      m_nmi_line = m_en && m_pend;       // the pin shows last clock's state
      rd = !nIORQ && !nRD;
      wr = !nIORQ && !nWR;
      p  = SDA[7:0] & 8'h1C;
      if (wr && !m_in_wr) begin
        if (p == 8'h00) m_pend = 0;
        if (p == 8'h08) m_en = 1;
        if (p == 8'h18) m_en = 0;
        if (p == 8'h0C) m_reply = SDD_WR;
      end
      if (rd && !m_in_rd) begin
        if (p == 8'h00) m_pend = 0;
        if (BANKING && p == 8'h08) m_bank[SDA[1:0]] = SDA[15:8];
      end
      if (SOUND_CMD_WR) begin
        m_cmd = SOUND_CMD;
        m_pend = 1;
      end
      m_in_rd = rd;
      m_in_wr = wr;
    end
  end

  always @(negedge CLK_24M) begin
    if (chk_en) begin
      bit rd, wr;
      int p;
      logic [7:0] e_io;
      rd = !nIORQ && !nRD;
      wr = !nIORQ && !nWR;
      p  = SDA[7:0] & 8'h1C;
      e_io = (p == 8'h00) ? m_cmd : (p == 8'h04) ? YM_DOUT : 8'hFF;
      chk("nNMI", nNMI, !m_nmi_line);
      chk("SOUND_REPLY", SOUND_REPLY, m_reply);
      chk("IO_RD", IO_RD, rd);
      chk("nYMCS", nYMCS, !((rd || wr) && p == 8'h04));
      chk("YM_A", YM_A, SDA[1:0]);
      chk("SDD_IO", SDD_IO, e_io);
      chk("BANK0", BANK0, m_bank[0]);
      chk("BANK1", BANK1, m_bank[1]);
      chk("BANK2", BANK2, m_bank[2]);
      chk("BANK3", BANK3, m_bank[3]);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK_24M);
      #2;
      SOUND_CMD_WR = 1'b0;
    end
  endtask

  task automatic bus_idle();
    nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
  endtask

  task automatic io(input bit is_wr, input logic [15:0] a, input logic [7:0] d, input int hold);
    SDA = a; SDD_WR = d; nIORQ = 1'b0;
    if (is_wr) nWR = 1'b0; else nRD = 1'b0;
    tick(hold);
    bus_idle();
    tick(1);
  endtask

  task automatic cmd(input logic [7:0] b);
    SOUND_CMD = b; SOUND_CMD_WR = 1'b1;
    tick(1);
  endtask

  initial begin
    logic [7:0] lows [12] = '{8'h00, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                              8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h18, 8'h1C};

    // Reset values
    tick(3);
    @(negedge CLK_24M);
    chk("rst nNMI", nNMI, 1'b1);
    chk("rst reply", SOUND_REPLY, 8'h00);
    chk("rst bank0", BANK0, 8'h1E);
    chk("rst bank1", BANK1, 8'h0E);
    chk("rst bank2", BANK2, 8'h06);
    chk("rst bank3", BANK3, 8'h02);
    chk("rst nYMCS", nYMCS, 1'b1);
    tick(1);
    nRESET = 1'b1;
    chk_en = 1'b1;
    tick(2);

    // NMI enable, command, acknowledge by reading the latch
    io(1, 16'h0008, 8'h00, 2);
    cmd(8'h55);
    @(negedge CLK_24M);
    chk("nmi not yet", nNMI, 1'b1);
    tick(1);
    @(negedge CLK_24M);
    chk("nmi low", nNMI, 1'b0);
    SDA = 16'h0000; nIORQ = 1'b0; nRD = 1'b0;
    @(negedge CLK_24M);
    chk("cmd read", SDD_IO, 8'h55);
    chk("io_rd high", IO_RD, 1'b1);
    tick(2);
    @(negedge CLK_24M);
    chk("nmi released", nNMI, 1'b1);
    bus_idle();
    tick(1);

    // Command strobe colliding with the acknowledge read
    SOUND_CMD = 8'h3C; SOUND_CMD_WR = 1'b1;
    SDA = 16'h0000; nIORQ = 1'b0; nRD = 1'b0;
    tick(2);
    bus_idle();
    tick(1);
    @(negedge CLK_24M);
    chk("collision nmi", nNMI, 1'b0);
    chk("collision cmd", SDD_IO, 8'h3C);
    io(1, 16'h0000, 8'h00, 1);

    // NMI gating
    io(1, 16'h0018, 8'h00, 1);
    cmd(8'hA1);
    tick(3);
    @(negedge CLK_24M);
    chk("gated nmi", nNMI, 1'b1);
    io(1, 16'h0008, 8'h00, 1);
    @(negedge CLK_24M);
    chk("enable nmi", nNMI, 1'b0);
    io(1, 16'h0018, 8'h00, 1);
    @(negedge CLK_24M);
    chk("disable nmi", nNMI, 1'b1);
    io(1, 16'h0000, 8'h00, 1);

    // Reply with a WAIT-stretched write; data changing late must not rewrite it
    SDA = 16'h000C; SDD_WR = 8'hA7; nIORQ = 1'b0; nWR = 1'b0;
    tick(5);
    SDD_WR = 8'h5A;
    tick(15);
    bus_idle();
    tick(1);
    @(negedge CLK_24M);
    chk("reply once", SOUND_REPLY, 8'hA7);
    SDA = 16'h0006; nIORQ = 1'b0; nWR = 1'b0;
    @(negedge CLK_24M);
    chk("ym cs", nYMCS, 1'b0);
    chk("ym a", YM_A, 2'd2);
    bus_idle();
    tick(1);

    // Bank register load
    SDA = 16'h3F0B; nIORQ = 1'b0; nRD = 1'b0;
    @(negedge CLK_24M);
    chk("bank rd data", SDD_IO, 8'hFF);
    tick(2);
    bus_idle();
    tick(1);
    @(negedge CLK_24M);
    chk("bank3 load", BANK3, BANKING ? 8'h3F : 8'h02);
    chk("bank0 kept", BANK0, 8'h1E);

    // Reset while a write is held: the write is seen again after release
    SDA = 16'h000C; SDD_WR = 8'h11; nIORQ = 1'b0; nWR = 1'b0;
    tick(3);
    nRESET = 1'b0;
    tick(1);
    @(negedge CLK_24M);
    chk("mid rst reply", SOUND_REPLY, 8'h00);
    nRESET = 1'b1;
    tick(2);
    @(negedge CLK_24M);
    chk("rewrite after rst", SOUND_REPLY, 8'h11);
    bus_idle();
    tick(2);

    // Randomised traffic against the model
    for (int it = 0; it < 1500; it++) begin
      int r, op, hold;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        nRESET = 1'b0;
        tick($urandom_range(1, 2));
        nRESET = 1'b1;
        tick(1);
        continue;
      end
      op   = $urandom_range(0, 3);
      hold = $urandom_range(1, 4);
      SDA[15:8] = 8'($urandom_range(0, 255));
      SDA[7:0]  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                               : lows[$urandom_range(0, 11)];
      SDD_WR = 8'($urandom_range(0, 255));
      nIORQ  = (op == 0);
      nRD    = !(op == 1);
      nWR    = !(op == 2);
      for (int h = 0; h < hold; h++) begin
        SOUND_CMD    = 8'($urandom_range(0, 255));
        SOUND_CMD_WR = ($urandom_range(0, 5) == 0);
        YM_DOUT      = 8'($urandom_range(0, 255));
        tick(1);
      end
      bus_idle();
      SOUND_CMD    = 8'($urandom_range(0, 255));
      SOUND_CMD_WR = ($urandom_range(0, 7) == 0);
      tick(1);
    end

    tick(2);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
